// File: rtl/fir_tdm_mc.sv
// Multi-channel FIR filter: a single time-multiplexed MAC serves NUM_CH interleaved channels.
// It has run-time loadable coefficients, valid/ready sink and source, and a saturating, rounded output.
module fir_tdm_mc #(
    parameter  int DATA_W    = 24,
    parameter  int COEF_W    = 18,
    parameter  int COEF_FRAC = 16,
    parameter  int TAPS      = 16,
    parameter  int NUM_CH    = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW        = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sink_data,
    input  logic [CH_W-1:0]   sink_channel,
    input  logic              sink_valid,
    input  logic              sink_error,
    output logic              sink_ready,
    output logic [DATA_W-1:0] source_data,
    output logic [CH_W-1:0]   source_channel,
    output logic              source_valid,
    output logic [1:0]        source_error,
    input  logic              source_ready,
    input  logic              coef_wr_en,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic              coef_ready
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + AW;

    localparam logic [AW-1:0]            IDX_LAST   = AW'(TAPS - 1);
    localparam logic [AW:0]              TAP_LIM    = (AW + 1)'(TAPS);
    localparam logic [CH_W:0]            CH_LIM     = (CH_W + 1)'(NUM_CH);
    localparam logic signed [ACC_W-1:0]  RND_HALF   = ACC_W'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0]  OUT_MAX    = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0]  OUT_MIN    = -(ACC_W'(1) <<< (DATA_W - 1));
    localparam logic signed [COEF_W-1:0] COEF_UNITY = COEF_W'(1) <<< COEF_FRAC;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_RND, S_OUT} state_t;

    function automatic logic signed [ACC_W-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
        return (a + RND_HALF) >>> COEF_FRAC;
    endfunction

    function automatic logic clips(input logic signed [ACC_W-1:0] y);
        return (y > OUT_MAX) || (y < OUT_MIN);
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] y);
        if (y > OUT_MAX) return OUT_MAX[DATA_W-1:0];
        if (y < OUT_MIN) return OUT_MIN[DATA_W-1:0];
        return y[DATA_W-1:0];
    endfunction

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] hist_q [NUM_CH][TAPS];
    logic        [AW-1:0]     wptr_q [NUM_CH];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic        [CH_W-1:0]   ch_q;
    logic                     err_q;
    logic        [AW-1:0]     k_q;
    logic        [AW-1:0]     rd_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic                     accept;
    logic                     ch_ok;
    logic                     coef_we;
    logic                     mac_last;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  y_rnd;

    always_comb begin
        accept   = sink_valid && (state_q == S_IDLE);
        ch_ok    = {1'b0, sink_channel} < CH_LIM;
        coef_we  = coef_wr_en && (state_q == S_IDLE) && ({1'b0, coef_addr} < TAP_LIM);
        mac_last = (k_q == IDX_LAST);
        prod     = PROD_W'(hist_q[ch_q][rd_q]) * PROD_W'(coef_q[k_q]);
        y_rnd    = round_half_up(acc_q);
    end

    assign sink_ready   = (state_q == S_IDLE);
    assign coef_ready   = (state_q == S_IDLE);
    assign source_valid = (state_q == S_OUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Samples on an out-of-range channel are consumed in IDLE without leaving it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && ch_ok) state_d = S_MAC;
            S_MAC:   if (mac_last)        state_d = S_RND;
            S_RND:                        state_d = S_OUT;
            S_OUT:   if (source_ready)    state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= '0;
                for (int t = 0; t < TAPS; t++) hist_q[c][t] <= '0;
            end
            for (int t = 0; t < TAPS; t++) coef_q[t] <= (t == 0) ? COEF_UNITY : '0;
            ch_q           <= '0;
            err_q          <= 1'b0;
            k_q            <= '0;
            rd_q           <= '0;
            acc_q          <= '0;
            source_data    <= '0;
            source_channel <= '0;
            source_error   <= '0;
        end else begin
            if (coef_we) coef_q[coef_addr] <= coef_wdata;
            case (state_q)
                S_IDLE: begin
                    if (accept && ch_ok) begin
                        hist_q[sink_channel][wptr_q[sink_channel]] <= sink_data;
                        ch_q  <= sink_channel;
                        err_q <= sink_error;
                        rd_q  <= wptr_q[sink_channel];
                        k_q   <= '0;
                        acc_q <= '0;
                    end
                end
                // Walk the history backwards from the newest sample while k walks the coefficients.
                S_MAC: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    k_q   <= k_q + AW'(1);
                    rd_q  <= (rd_q == '0) ? IDX_LAST : rd_q - AW'(1);
                    if (mac_last)
                        wptr_q[ch_q] <= (wptr_q[ch_q] == IDX_LAST) ? '0 : wptr_q[ch_q] + AW'(1);
                end
                S_RND: begin
                    source_data    <= saturate(y_rnd);
                    source_channel <= ch_q;
                    source_error   <= {err_q, clips(y_rnd)};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_tdm_mc.sv
// Directed and randomized bench for fir_tdm_mc, checked against a shift-register FIR model.
module tb_fir_tdm_mc;
    localparam int DATA_W    = 24;
    localparam int COEF_W    = 18;
    localparam int COEF_FRAC = 16;
    localparam int TAPS      = 16;
    localparam int NUM_CH    = 2;
    localparam int CH_W      = 1;
    localparam int AW        = 4;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [DATA_W-1:0]        sink_data = '0;
    logic [CH_W-1:0]          sink_channel = '0;
    logic                     sink_valid = 1'b0;
    logic                     sink_error = 1'b0;
    logic                     sink_ready;
    logic signed [DATA_W-1:0] source_data;
    logic [CH_W-1:0]          source_channel;
    logic                     source_valid;
    logic [1:0]               source_error;
    logic                     source_ready = 1'b0;
    logic                     coef_wr_en = 1'b0;
    logic [AW-1:0]            coef_addr = '0;
    logic [COEF_W-1:0]        coef_wdata = '0;
    logic                     coef_ready;

    int checks = 0;
    int failures = 0;
    longint mcoef [TAPS];
    longint mhist [NUM_CH][TAPS];
    logic signed [DATA_W-1:0] last_y;
    logic [1:0]               last_err;

    always #5 clk = ~clk;

    fir_tdm_mc #(.DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC),
                 .TAPS(TAPS), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .reset_n(reset_n),
        .sink_data(sink_data), .sink_channel(sink_channel), .sink_valid(sink_valid),
        .sink_error(sink_error), .sink_ready(sink_ready),
        .source_data(source_data), .source_channel(source_channel),
        .source_valid(source_valid), .source_error(source_error), .source_ready(source_ready),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_ready(coef_ready)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int t = 0; t < TAPS; t++) begin
            mcoef[t] = (t == 0) ? (64'sd1 <<< COEF_FRAC) : 0;
            for (int c = 0; c < NUM_CH; c++) mhist[c][t] = 0;
        end
    endfunction

    // Direct-form FIR: index 0 holds the newest sample of the channel.
    function automatic void model_push(input int ch, input longint x, output longint y, output logic clip);
        longint sum = 0;
        longint lo = -(64'sd1 <<< (DATA_W - 1));
        longint hi = (64'sd1 <<< (DATA_W - 1)) - 1;
        for (int k = TAPS - 1; k > 0; k--) mhist[ch][k] = mhist[ch][k-1];
        mhist[ch][0] = x;
        for (int k = 0; k < TAPS; k++) sum += mhist[ch][k] * mcoef[k];
        y = (sum + (64'sd1 <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
        clip = (y > hi) || (y < lo);
        if (y > hi) y = hi;
        if (y < lo) y = lo;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic wr_coef(input int addr, input logic [COEF_W-1:0] val);
        int n = 0;
        coef_wr_en = 1'b1;
        coef_addr  = AW'(addr);
        coef_wdata = val;
        while (!coef_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("coef_ready_wait", (n < 50), 1);
        @(posedge clk);
        @(negedge clk);
        coef_wr_en = 1'b0;
        mcoef[addr] = longint'($signed(val));
    endtask

    // Called at a negedge while idle. The result is visible in the (TAPS+2)th cycle, counting the accept cycle as the first.
    task automatic send(input string tag, input int ch, input logic [DATA_W-1:0] d, input logic e,
                        input int hold, input logic hold_wr,
                        input logic co_en, input int co_addr, input logic [COEF_W-1:0] co_val);
        longint ey;
        logic   eclip;
        chk({tag, "_sink_ready_pre"}, sink_ready, 1);
        sink_valid   = 1'b1;
        sink_channel = CH_W'(ch);
        sink_data    = d;
        sink_error   = e;
        coef_wr_en   = co_en;
        coef_addr    = AW'(co_addr);
        coef_wdata   = co_val;
        @(posedge clk);
        @(negedge clk);
        sink_valid = 1'b0;
        coef_wr_en = 1'b0;
        if (co_en) mcoef[co_addr] = longint'($signed(co_val));
        model_push(ch, longint'($signed(d)), ey, eclip);
        repeat (TAPS) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, "_valid_early"}, source_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, source_valid, 1);
        chk({tag, "_data"}, source_data, ey);
        chk({tag, "_chan"}, source_channel, ch);
        chk({tag, "_err"}, source_error, {e, eclip});
        last_y   = source_data;
        last_err = source_error;
        for (int i = 0; i < hold; i++) begin
            if (hold_wr) begin
                coef_wr_en = 1'b1;
                coef_addr  = AW'(1);
                coef_wdata = COEF_W'(1 << COEF_FRAC);
            end
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, source_valid, 1);
            chk({tag, "_hold_data"}, source_data, last_y);
            chk({tag, "_hold_sink_ready"}, sink_ready, 0);
            if (hold_wr) chk({tag, "_hold_coef_ready"}, coef_ready, 0);
        end
        coef_wr_en   = 1'b0;
        source_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        source_ready = 1'b0;
        chk({tag, "_valid_after"}, source_valid, 0);
        chk({tag, "_sink_ready_after"}, sink_ready, 1);
    endtask

    task automatic send_simple(input string tag, input int ch, input logic [DATA_W-1:0] d, input logic e);
        send(tag, ch, d, e, 0, 1'b0, 1'b0, 0, '0);
    endtask

    initial begin
        int seen;
        model_reset();
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_sink_ready", sink_ready, 1);
        chk("rst_coef_ready", coef_ready, 1);
        chk("rst_source_valid", source_valid, 0);
        chk("rst_source_data", source_data, 0);
        chk("rst_source_chan", source_channel, 0);
        chk("rst_source_err", source_error, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Default coefficients pass samples straight through
        send_simple("t1a", 0, 24'd1000, 1'b0);
        chk("t1a_const", last_y, 1000);
        send_simple("t1b", 0, DATA_W'(-5000), 1'b0);
        chk("t1b_const", last_y, -5000);
        send_simple("t1c", 0, 24'h7FFFFF, 1'b0);
        chk("t1c_const", last_y, 24'sh7FFFFF);
        chk("t1c_err", last_err, 2'b00);
        send_simple("t1d", 0, 24'd42, 1'b1);
        chk("t1d_err", last_err, 2'b10);

        // Moving average ramp
        apply_reset();
        for (int k = 0; k < TAPS; k++) wr_coef(k, COEF_W'(1 << 12));
        for (int n = 1; n <= 20; n++) begin
            send_simple("t2", 0, 24'd160000, 1'b0);
            chk("t2_ramp", last_y, 10000 * ((n < TAPS) ? n : TAPS));
        end

        // Saturation positive then negative
        apply_reset();
        wr_coef(1, COEF_W'(1 << COEF_FRAC));
        send_simple("t3p1", 0, 24'h7FFFFF, 1'b0);
        chk("t3p1_err", last_err, 2'b00);
        send_simple("t3p2", 0, 24'h7FFFFF, 1'b0);
        chk("t3p2_const", last_y, 24'sh7FFFFF);
        chk("t3p2_err", last_err, 2'b01);
        apply_reset();
        wr_coef(1, COEF_W'(1 << COEF_FRAC));
        send_simple("t3n1", 1, 24'h800000, 1'b0);
        send_simple("t3n2", 1, 24'h800000, 1'b0);
        chk("t3n2_const", last_y, -(64'sd1 <<< 23));
        chk("t3n2_err", last_err, 2'b01);

        // Interleaved channels keep separate histories
        apply_reset();
        wr_coef(1, COEF_W'(1 << 15));
        send_simple("t4a", 0, 24'd4096, 1'b0);
        chk("t4a_const", last_y, 4096);
        send_simple("t4b", 1, 24'd0, 1'b0);
        chk("t4b_const", last_y, 0);
        send_simple("t4c", 0, 24'd0, 1'b0);
        chk("t4c_const", last_y, 2048);
        send_simple("t4d", 1, 24'd0, 1'b0);
        chk("t4d_const", last_y, 0);
        send_simple("t4e", 0, 24'd0, 1'b0);
        chk("t4e_const", last_y, 0);

        // Coefficient written in the same cycle as the sample applies to it
        apply_reset();
        send("tsame", 0, 24'd1000, 1'b0, 0, 1'b0, 1'b1, 0, COEF_W'(1 << 15));
        chk("tsame_const", last_y, 500);

        // Backpressure: output held, writes refused, single transfer
        apply_reset();
        send("t5", 1, 24'd777, 1'b0, 10, 1'b1, 1'b0, 0, '0);
        chk("t5_const", last_y, 777);
        send_simple("t5_next", 1, 24'd0, 1'b0);
        chk("t5_next_const", last_y, 0);

        // Reset in the middle of the MAC sequence
        apply_reset();
        wr_coef(3, COEF_W'(1 << 14));
        sink_valid = 1'b1; sink_channel = 1'b0; sink_data = 24'd5555;
        @(posedge clk);
        @(negedge clk);
        sink_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_sink_ready", sink_ready, 1);
        chk("t6_rst_valid", source_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        seen = 0;
        for (int i = 0; i < TAPS + 6; i++) begin
            @(negedge clk);
            if (source_valid) seen++;
        end
        chk("t6_no_output", seen, 0);
        for (int k = 1; k < 4; k++) wr_coef(k, COEF_W'(1 << COEF_FRAC));
        send_simple("t6_imp", 0, 24'd100, 1'b0);
        chk("t6_imp_const", last_y, 100);

        // Randomized traffic against the model
        apply_reset();
        for (int k = 0; k < TAPS; k++) begin
            logic [15:0] c16;
            c16 = 16'($urandom);
            wr_coef(k, {{2{c16[15]}}, c16});
        end
        for (int r = 0; r < 40; r++) begin
            logic [DATA_W-1:0] d;
            logic [15:0]       s16;
            if (r % 6 == 5) wr_coef($urandom_range(0, TAPS - 1), COEF_W'($urandom));
            s16 = 16'($urandom);
            d = (r % 3 == 0) ? DATA_W'($urandom) : {{8{s16[15]}}, s16};
            send("rnd", $urandom_range(0, NUM_CH - 1), d, 1'($urandom), $urandom_range(0, 2),
                 1'b0, (r % 7 == 3), $urandom_range(0, TAPS - 1), COEF_W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
